// File: rtl/sort_unloader_if.sv
// sort_unloader_if
//   Groups the vector-capture and element-stream handshake signals of
//   sort_unloader into one bundle.
//
//   Parameters:
//     DATA_W   element width in bits
//     LOG_SIZE log2 of elements per vector
//
//   Signals:
//     i_valid      one-cycle strobe, i_din holds a sorted vector
//     i_din        sorted vector, element k = i_din[DATA_W*k +: DATA_W]
//     o_can_accept a vector presented this cycle will be stored
//     o_valid      o_data holds a valid element
//     i_ready      sink accepts o_data this cycle
//     o_data       current element
//     o_last       o_data is the final element of its vector
//     o_overflow   sticky, at least one vector was dropped since reset
//
//   Modports:
//     master  environment side (sort network + sink)
//     slave   sort_unloader side
interface sort_unloader_if #(
  parameter int DATA_W   = 8,
  parameter int LOG_SIZE = 4
);
  localparam int SIZE = 2 ** LOG_SIZE;

  logic                   i_valid;
  logic [DATA_W*SIZE-1:0] i_din;
  logic                   o_can_accept;
  logic                   o_valid;
  logic                   i_ready;
  logic [DATA_W-1:0]      o_data;
  logic                   o_last;
  logic                   o_overflow;

  modport master (
    output i_valid, i_din, i_ready,
    input  o_can_accept, o_valid, o_data, o_last, o_overflow
  );

  modport slave (
    input  i_valid, i_din, i_ready,
    output o_can_accept, o_valid, o_data, o_last, o_overflow
  );
endinterface

// File: rtl/sort_unloader.sv
// sort_unloader
//   Downstream stage of the sort network. Captures one sorted vector per
//   i_valid pulse into a two-slot ping-pong buffer and streams its elements
//   out one per cycle over a valid/ready handshake. The sort network cannot
//   stall, so a vector arriving while both slots are busy is dropped and
//   the sticky o_overflow flag is raised.
//
//   Optional feature (macro SORT_UNLOAD_TOPK_EN):
//     when defined, only elements 0..TOPK-1 of each vector are emitted and
//     o_last marks element TOPK-1; otherwise all SIZE elements are emitted.
//
//   Parameters:
//     DATA_W   element width in bits
//     LOG_SIZE log2 of elements per vector (SIZE = 2**LOG_SIZE, derived)
//     TOPK     elements emitted per vector with SORT_UNLOAD_TOPK_EN, 1..SIZE
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  sort_unloader_if.slave (i_valid, i_din, i_ready in;
//          o_can_accept, o_valid, o_data, o_last, o_overflow out)
module sort_unloader #(
  parameter int DATA_W   = 8,
  parameter int LOG_SIZE = 4,
  parameter int TOPK     = 2 ** LOG_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  sort_unloader_if.slave  bus
);
  localparam int SIZE = 2 ** LOG_SIZE;

`ifdef SORT_UNLOAD_TOPK_EN
  localparam bit TOPK_EN = 1'b1;
`else
  localparam bit TOPK_EN = 1'b0;
`endif

  // Out-of-range TOPK values are clamped into 1..SIZE so the last-element
  // index always lands inside the stored vector.
  localparam int TOPK_CLAMP = (TOPK < 1) ? 1 : ((TOPK > SIZE) ? SIZE : TOPK);
  localparam int LAST_INT   = TOPK_EN ? (TOPK_CLAMP - 1) : (SIZE - 1);
  localparam logic [LOG_SIZE-1:0] LAST = LOG_SIZE'(LAST_INT);

  logic [DATA_W*SIZE-1:0] slot [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic [LOG_SIZE-1:0]    elem_idx;
  logic                   overflow;

  logic                   valid;
  logic                   last;
  logic                   transfer;
  logic                   pop_done;
  logic                   can_accept;
  logic                   capture;
  logic                   drop;
  logic [DATA_W*SIZE-1:0] front;
  logic [DATA_W-1:0]      data;

  // Handshake decode. A full buffer can still accept when the front slot is
  // being freed in the same cycle; the incoming vector then lands in the
  // slot that is just being released (wr_ptr == rd_ptr when full).
  always_comb begin
    valid      = (count != 2'd0);
    last       = valid && (elem_idx == LAST);
    transfer   = valid && bus.i_ready;
    pop_done   = transfer && last;
    can_accept = (count < 2'd2) || pop_done;
    capture    = bus.i_valid && can_accept;
    drop       = bus.i_valid && !can_accept;
  end

  // Element select from the front slot; forced to zero when idle.
  always_comb begin
    front = slot[rd_ptr];
    data  = '0;
    if (valid) begin
      data = front[int'(elem_idx)*DATA_W +: DATA_W];
    end
  end

  assign bus.o_valid      = valid;
  assign bus.o_last       = last;
  assign bus.o_data       = data;
  assign bus.o_can_accept = can_accept;
  assign bus.o_overflow   = overflow;

  // Control state: pointers, occupancy, stream position and the sticky
  // overflow flag. Capture and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      elem_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (transfer) begin
        elem_idx <= last ? '0 : elem_idx + 1'b1;
      end
      if (pop_done) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({capture, pop_done})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Slot storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot[wr_ptr] <= bus.i_din;
    end
  end
endmodule

// File: tb/tb_sort_unloader.sv
// tb_sort_unloader
//   Directed bench for sort_unloader with DATA_W=8, LOG_SIZE=2 (SIZE=4).
//   Each accepted vector pushes its expected elements into a queue; a
//   monitor pops and compares whenever an element is transferred.
//   Built with SORT_UNLOAD_TOPK_EN the DUT runs with TOPK=2.
module tb_sort_unloader;
  localparam int DATA_W   = 8;
  localparam int LOG_SIZE = 2;
  localparam int SIZE     = 4;
`ifdef SORT_UNLOAD_TOPK_EN
  localparam int TB_TOPK  = 2;
  localparam int NEMIT    = TB_TOPK;
`else
  localparam int TB_TOPK  = SIZE;
  localparam int NEMIT    = SIZE;
`endif
  // Position of the element presented when the reset scenario strikes.
  localparam int RST_ADV  = (NEMIT > 2) ? 2 : NEMIT - 1;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  sort_unloader_if #(.DATA_W(DATA_W), .LOG_SIZE(LOG_SIZE)) bus ();

  sort_unloader #(
    .DATA_W  (DATA_W),
    .LOG_SIZE(LOG_SIZE),
    .TOPK    (TB_TOPK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario wedges
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushVector(input logic [31:0] vec);
    for (int k = 0; k < NEMIT; k++) begin
      exp_t e;
      e.data = vec[8*k +: 8];
      e.last = (k == NEMIT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for exactly one cycle
  task automatic applyStimulus(input logic [31:0] vec, input bit accepted);
    bus.i_valid = 1'b1;
    bus.i_din   = vec;
    if (accepted) pushVector(vec);
    tick();
    bus.i_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected element has left and the DUT idles
  task automatic waitDrain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.o_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({name, " drained"}, 32'(done), 32'd1);
    checkOutput({name, " idle o_data"}, 32'(bus.o_data), 32'd0);
  endtask

  // Scoreboard monitor: compares each transferred element against the queue
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected output: got 0x%0h, expected no element", bus.o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("stream data", 32'(bus.o_data), 32'(e.data));
        checkOutput("stream last", 32'(bus.o_last), 32'(e.last));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_din   = '0;
    bus.i_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    checkOutput("reset o_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("reset o_last", 32'(bus.o_last), 32'd0);
    checkOutput("reset o_data", 32'(bus.o_data), 32'd0);
    checkOutput("reset o_can_accept", 32'(bus.o_can_accept), 32'd1);
    checkOutput("reset o_overflow", 32'(bus.o_overflow), 32'd0);
    tick();
    rst = 1'b0;

    // Single vector, sink always ready
    bus.i_ready = 1'b1;
    applyStimulus(32'h40302010, 1'b1);
    waitDrain("single");
    checkOutput("single o_overflow", 32'(bus.o_overflow), 32'd0);

    // Sink stalls three cycles on element 0
    bus.i_ready = 1'b0;
    applyStimulus(32'h40302010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold o_valid", 32'(bus.o_valid), 32'd1);
      checkOutput("hold o_data", 32'(bus.o_data), 32'h10);
      checkOutput("hold o_last", 32'(bus.o_last), 32'd0);
    end
    tick();
    bus.i_ready = 1'b1;
    waitDrain("hold");

    // Full buffer, new vector arrives as the front slot's last element leaves
    bus.i_ready = 1'b0;
    applyStimulus(32'h14131211, 1'b1);
    applyStimulus(32'h18171615, 1'b1);
    @(negedge clk);
    checkOutput("full o_can_accept", 32'(bus.o_can_accept), 32'd0);
    tick();
    bus.i_ready = 1'b1;
    for (int i = 0; i < NEMIT - 1; i++) tick();
    bus.i_valid = 1'b1;
    bus.i_din   = 32'h1C1B1A19;
    @(negedge clk);
    checkOutput("pop+capture o_last", 32'(bus.o_last), 32'd1);
    checkOutput("pop+capture o_can_accept", 32'(bus.o_can_accept), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    pushVector(32'h1C1B1A19);
    waitDrain("pop+capture");
    checkOutput("pop+capture o_overflow", 32'(bus.o_overflow), 32'd0);

    // Three vectors back to back with the sink stalled: the third is dropped
    bus.i_ready = 1'b0;
    applyStimulus(32'h04030201, 1'b1);
    applyStimulus(32'h08070605, 1'b1);
    bus.i_valid = 1'b1;
    bus.i_din   = 32'h0C0B0A09;
    @(negedge clk);
    checkOutput("drop o_can_accept", 32'(bus.o_can_accept), 32'd0);
    checkOutput("drop o_overflow before", 32'(bus.o_overflow), 32'd0);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    checkOutput("drop o_overflow after", 32'(bus.o_overflow), 32'd1);
    tick();
    bus.i_ready = 1'b1;
    waitDrain("drop");
    checkOutput("drop o_overflow sticky", 32'(bus.o_overflow), 32'd1);

    // Reset mid-stream with a second vector buffered
    bus.i_ready = 1'b0;
    applyStimulus(32'h44332211, 1'b1);
    applyStimulus(32'h88776655, 1'b1);
    bus.i_ready = 1'b1;
    for (int i = 0; i < RST_ADV; i++) tick();
    @(negedge clk);
    checkOutput("pre-reset o_data", 32'(bus.o_data), 32'(8'h11 * (RST_ADV + 1)));
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("midreset o_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("midreset o_data", 32'(bus.o_data), 32'd0);
    checkOutput("midreset o_overflow", 32'(bus.o_overflow), 32'd0);
    checkOutput("midreset o_can_accept", 32'(bus.o_can_accept), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset o_valid", 32'(bus.o_valid), 32'd0);
    applyStimulus(32'hDDCCBBAA, 1'b1);
    waitDrain("post-reset");

    // Two vectors back to back with the sink ready: no bubble between them
    bus.i_ready = 1'b1;
    applyStimulus(32'h40302010, 1'b1);
    applyStimulus(32'h80706050, 1'b1);
    for (int i = 0; i < 2 * NEMIT - 1; i++) begin
      @(negedge clk);
      checkOutput("gapless o_valid", 32'(bus.o_valid), 32'd1);
    end
    waitDrain("gapless");

    checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sort_unloader.md
Name: sort_unloader

Overview:
- Downstream stage of the sort network: captures one full sorted vector (SIZE elements of DATA_W bits) per i_valid pulse.
- Streams the elements out one per cycle over a valid/ready interface.
- Holds two vectors in a ping-pong buffer, which absorbs sink backpressure while the pipelined, non-stallable sort network keeps producing.
- Flags any vector it has to drop.

Parameters:
- DATA_W, 8, element width in bits.
- LOG_SIZE, 4, log2 of elements per vector.
- SIZE, 2 ** LOG_SIZE, elements per vector (derived; do not override).
- TOPK, SIZE, elements emitted per vector when SORT_UNLOAD_TOPK_EN is defined; legal range 1..SIZE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  one-cycle strobe: i_din holds a sorted vector this cycle.
- i_din  input  DATA_W*SIZE  sorted vector; element k = i_din[DATA_W*k +: DATA_W].
- o_can_accept  output  1  high when a vector presented this cycle will be stored.
- o_valid  output  1  o_data holds a valid element.
- i_ready  input  1  sink accepts o_data this cycle.
- o_data  output  DATA_W  current element.
- o_last  output  1  o_data is the final element of its vector.
- o_overflow  output  1  sticky: at least one vector was dropped since reset.

Behaviour:
- Reset: asynchronous assertion, synchronous-to-clk deassertion assumed upstream. All of the following clear to 0 immediately: count, wr_ptr, rd_ptr, elem_idx, o_overflow. In reset: o_valid=0, o_last=0, o_data=0, o_can_accept=1.
- Reset mid-stream discards both buffered vectors and the partial stream. No further o_valid until a new vector is captured.
- Storage: two slots of DATA_W*SIZE bits; no reset needed on slot contents.
- Pointers and indices:
  - wr_ptr and rd_ptr are 1-bit.
  - count ranges 0..2.
  - elem_idx is LOG_SIZE bits and wraps to 0 after the last element.
- Transfer: occurs when o_valid & i_ready.
  - On transfer, elem_idx increments.
  - On the transfer with o_last=1: elem_idx returns to 0, rd_ptr toggles, and count decrements (slot freed).
- pop_done = transfer & o_last.
- o_can_accept = (count<2) | pop_done. This is combinational from state and i_ready.
- Capture: on i_valid & o_can_accept, slot[wr_ptr] <= i_din, wr_ptr toggles, count increments.
- Simultaneous capture and pop_done: count is unchanged.
- Drop: on i_valid & !o_can_accept, the vector is discarded, o_overflow <= 1 and held until rst, and no other state changes.
- o_valid = (count!=0).
- o_data = slot[rd_ptr] element elem_idx when o_valid, else 0.
- o_last = o_valid & (elem_idx==LAST), where LAST=SIZE-1 (or TOPK-1, see option).
- Latency: vector captured at edge N into an empty buffer gives o_valid=1 with element 0 in the cycle after edge N. Elements 1..LAST follow on successive transfers.
- Throughput: one element per cycle with i_ready held high. Back-to-back vectors stream without a bubble, with element 0 of the next slot immediately following o_last.
- Stability: while o_valid & !i_ready, o_data and o_last hold constant. A capture into the other slot must not disturb them.
- count never exceeds 2. The drop path is the only response to a third vector.

Optional Feature:
- SORT_UNLOAD_TOPK_EN defined:
  - Only elements 0..TOPK-1 of each vector are emitted.
  - o_last is asserted on element TOPK-1, and that transfer frees the slot.
  - Elements TOPK..SIZE-1 are never presented.
- Not defined: TOPK is ignored and all SIZE elements are emitted.
- Storage width is unchanged in both cases.

Test Plan (DATA_W=8, LOG_SIZE=2, SIZE=4):
- Single vector 0x40302010 pulsed, i_ready=1 -> next 4 cycles o_data=0x10,0x20,0x30,0x40. o_last only with 0x40. Then o_valid=0. o_overflow=0.
- Same vector, i_ready=0 for 3 cycles after o_valid rises -> o_data holds 0x10 and o_last=0 throughout. Then the stream resumes 0x10..0x40 in order with no loss or duplication.
- Vectors A=0x04030201, B=0x08070605, C=0x0C0B0A09 on consecutive cycles, i_ready=0 -> C dropped: o_can_accept=0 during C and o_overflow=1 the next cycle. Release i_ready -> 01..04, 08-free gap-less 05..08 (o_last on 04 and 08), then o_valid=0.
- count=2 and the sink taking o_last of the front slot in the same cycle a new vector pulses -> vector accepted (o_can_accept=1), o_overflow stays 0, and its elements stream after the remaining buffered vector.
- Assert rst while element 2 of a vector is being presented with a second vector buffered -> o_valid=0, o_data=0, o_overflow=0 immediately. After release, a new vector 0xDDCCBBAA streams AA,BB,CC,DD from element 0.
- SORT_UNLOAD_TOPK_EN with TOPK=2, vectors 0x40302010 then 0x80706050, i_ready=1 -> o_data 0x10,0x20(last),0x50,0x60(last). Elements 0x30, 0x40, 0x70 and 0x80 are never output.
